keypad_emulator: RTL and testbench
==================================

KEYPAD_EMULATOR -- requirements
Module: keypad_emulator

Interface
REQ-001 Parameter BOUNCE_CYCLES, default 16: length in clocks of each bounce window (press and release); 0 disables bouncing.
REQ-002 Parameter TOGGLE_PERIOD, default 4: clocks between contact toggles inside a bounce window; legal range >= 1.
REQ-003 Parameter HOLD_CYCLES, default 64: clocks of stable closed contact between the two bounce windows; legal range >= 1.
REQ-004 Port list, clock and reset first; the block has one clock, and reset is asynchronous and active-high.
- clk_50MHz_i  in  1  system clock; all state updates on the rising edge.
- rst_async_ha_i  in  1  asynchronous active-high reset.
- rows_i  in  4  row scan driven by the keypad scanner; active-high, one-hot during a scan.
- key_code_i  in  4  key to press; row = key_code_i[3:2], column = key_code_i[1:0].
- press_i  in  1  request for one complete press/hold/release cycle of key_code_i.
- columns_o  out  4  emulated column lines to the scanner; active-high; idle value 4'b0000.
- busy_o  out  1  high while a press sequence is in progress.
- done_o  out  1  one-cycle pulse when a sequence completes.

Function
REQ-005 The FSM SHALL have the states IDLE, BOUNCE_IN, HELD and BOUNCE_OUT.
REQ-006 In IDLE, press_i=1 at a rising edge SHALL latch key_code_i and SHALL move the FSM to BOUNCE_IN, or to HELD if BOUNCE_CYCLES=0; the phase counter SHALL be cleared.
REQ-007 Outside IDLE, press_i SHALL be ignored: no queueing and no re-latching of key_code_i.
REQ-008 BOUNCE_IN SHALL last exactly BOUNCE_CYCLES clocks.
- contact = 1 when floor(cnt/TOGGLE_PERIOD) is even, 0 otherwise.
- cnt runs from 0 to BOUNCE_CYCLES-1.
- The FSM then moves to HELD.
REQ-009 HELD SHALL last exactly HOLD_CYCLES clocks with contact = 1, then move to BOUNCE_OUT, or to IDLE if BOUNCE_CYCLES=0.
REQ-010 BOUNCE_OUT SHALL last exactly BOUNCE_CYCLES clocks, then move to IDLE.
- contact = 1 when floor(cnt/TOGGLE_PERIOD) is odd, 0 otherwise, so the window starts open.
REQ-011 In IDLE, contact SHALL be 0.
REQ-012 columns_o SHALL be registered: columns_o(t+1)[c] = contact(t) AND rows_i(t)[latched row] AND (c == latched column). All other bits SHALL be 0.
REQ-013 The latency from rows_i to columns_o SHALL be exactly one clock.
- rows_i = 0 yields columns_o = 0.
- A non-one-hot rows_i SHALL still respond only on the latched row bit.
REQ-014 busy_o SHALL be registered high on every cycle where state != IDLE.
REQ-015 done_o SHALL go high for exactly one clock, on the edge where the FSM enters IDLE from HELD or BOUNCE_OUT; busy_o SHALL fall on that same edge.
REQ-016 press_i high on the same edge as done_o SHALL be ignored, because the FSM is not yet in IDLE. A new press SHALL be accepted on the following edge.
REQ-017 The phase counter SHALL be wide enough for max(BOUNCE_CYCLES, HOLD_CYCLES) with no wrap-around; it SHALL clear on every state change.
REQ-018 key_code_i changes while busy_o=1 SHALL NOT affect columns_o.

Reset
REQ-019 rst_async_ha_i=1 SHALL immediately force the following, independent of the clock:
- state = IDLE;
- counter = 0;
- latched key = 0;
- columns_o = 4'b0000, busy_o = 0, done_o = 0.
REQ-020 Reset mid-sequence SHALL abort the sequence with no done_o pulse. After release, the first rising edge with press_i=1 SHALL start a new sequence.

Verification
REQ-021 Clean press (BOUNCE_CYCLES=0, HOLD_CYCLES=8, key 4'b0110, rows_i=4'b0010 constant, press_i pulsed at edge 0):
- columns_o = 4'b0100 on edges 1..8, then 0;
- busy_o high on edges 0..7;
- done_o high only after edge 8.
REQ-022 Row gating: same setup with rows_i cycling 0001, 0010, 0100, 1000 every clock -> columns_o = 4'b0100 only on the cycle following rows_i = 0010, otherwise 0.
REQ-023 Bounce (defaults, key 4'b0000, rows_i=4'b0001) -> columns_o[0] pattern is:
- 1111 0000 1111 0000;
- then 64 ones;
- then 0000 1111 0000 1111;
- then 0.
REQ-024 Busy press: second press_i with key 4'b1111 during HELD -> ignored; columns_o still reflects key 4'b0110; exactly one done_o pulse.
REQ-025 Async reset: assert rst_async_ha_i mid-HELD between clock edges -> columns_o, busy_o and done_o read 0 before the next edge. No done_o after release; a subsequent press_i completes normally.
REQ-026 Back-to-back: press_i held high continuously -> sequences repeat, with exactly one IDLE cycle between done_o and the next busy_o rise.

Source files
------------

// File: rtl/keypad_emulator.sv
// Emulates one key of a 4x4 matrix keypad: on request it closes the selected
// row/column contact with bounce on both edges, answering the scanner's row drive.
module keypad_emulator #(
    parameter int BOUNCE_CYCLES = 16,
    parameter int TOGGLE_PERIOD = 4,
    parameter int HOLD_CYCLES   = 64
) (
    input  logic       clk_50MHz_i,
    input  logic       rst_async_ha_i,
    input  logic [3:0] rows_i,
    input  logic [3:0] key_code_i,
    input  logic       press_i,
    output logic [3:0] columns_o,
    output logic       busy_o,
    output logic       done_o
);

    localparam int MAX_CYCLES = (BOUNCE_CYCLES > HOLD_CYCLES) ? BOUNCE_CYCLES : HOLD_CYCLES;
    localparam int CW = (MAX_CYCLES < 1) ? 1 : $clog2(MAX_CYCLES + 1);
    localparam logic [CW-1:0] BOUNCE_LAST = CW'(BOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        BOUNCE_IN,
        HELD,
        BOUNCE_OUT
    } state_t;

    state_t        state;
    state_t        next_state;
    logic [CW-1:0] cnt;
    logic [3:0]    key;
    logic          contact;
    logic          phase_odd;

    // Parity of the toggle slot the counter currently sits in.
    always_comb begin
        phase_odd = 1'((32'(cnt) / 32'(TOGGLE_PERIOD)) % 32'd2);
    end

    always_ff @(posedge clk_50MHz_i or posedge rst_async_ha_i) begin
        if (rst_async_ha_i) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        contact    = 1'b0;
        case (state)
            IDLE: begin
                if (press_i) begin
                    next_state = (BOUNCE_CYCLES == 0) ? HELD : BOUNCE_IN;
                end
            end
            BOUNCE_IN: begin
                contact = ~phase_odd;
                if (cnt == BOUNCE_LAST) begin
                    next_state = HELD;
                end
            end
            HELD: begin
                contact = 1'b1;
                if (cnt == HOLD_LAST) begin
                    next_state = (BOUNCE_CYCLES == 0) ? IDLE : BOUNCE_OUT;
                end
            end
            BOUNCE_OUT: begin
                contact = phase_odd;
                if (cnt == BOUNCE_LAST) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Counter idles at zero and restarts on every state change; the key is
    // only captured when a sequence starts so later code changes are ignored.
    always_ff @(posedge clk_50MHz_i or posedge rst_async_ha_i) begin
        if (rst_async_ha_i) begin
            cnt       <= '0;
            key       <= 4'b0000;
            columns_o <= 4'b0000;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
        end else begin
            if ((next_state != state) || (state == IDLE)) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
            if ((state == IDLE) && press_i) begin
                key <= key_code_i;
            end
            columns_o <= (contact && rows_i[key[3:2]]) ? (4'b0001 << key[1:0]) : 4'b0000;
            busy_o    <= (next_state != IDLE);
            done_o    <= (state != IDLE) && (next_state == IDLE);
        end
    end

endmodule

// File: tb/tb_keypad_emulator.sv
// Bench for keypad_emulator: a clean-contact and a bouncing instance share the
// same stimulus and are compared against a sequence-level reference model.
module tb_keypad_emulator;

    localparam int TP = 4;

    logic       clk      = 1'b0;
    logic       rst      = 1'b0;
    logic [3:0] rows     = 4'b0000;
    logic [3:0] key_code = 4'b0000;
    logic       press    = 1'b0;
    logic [3:0] cols [2];
    logic       busy [2];
    logic       done [2];

    int n_checks = 0;
    int n_fail   = 0;

    keypad_emulator #(.BOUNCE_CYCLES(0), .TOGGLE_PERIOD(TP), .HOLD_CYCLES(8)) dut_clean (
        .clk_50MHz_i(clk), .rst_async_ha_i(rst), .rows_i(rows), .key_code_i(key_code),
        .press_i(press), .columns_o(cols[0]), .busy_o(busy[0]), .done_o(done[0])
    );

    keypad_emulator #(.BOUNCE_CYCLES(16), .TOGGLE_PERIOD(TP), .HOLD_CYCLES(64)) dut_bounce (
        .clk_50MHz_i(clk), .rst_async_ha_i(rst), .rows_i(rows), .key_code_i(key_code),
        .press_i(press), .columns_o(cols[1]), .busy_o(busy[1]), .done_o(done[1])
    );

    always #10 clk = ~clk;

    function automatic int bounce_of(int k);
        return (k == 0) ? 0 : 16;
    endfunction

    function automatic int hold_of(int k);
        return (k == 0) ? 8 : 64;
    endfunction

    // Contact level at position pos of a whole press: bounce-in, hold, bounce-out.
    function automatic bit contact_at(int k, int pos);
        int b;
        int h;
        b = bounce_of(k);
        h = hold_of(k);
        if (pos < b) return ((pos / TP) % 2) == 0;
        if (pos < b + h) return 1'b1;
        return (((pos - b - h) / TP) % 2) == 1;
    endfunction

    bit         m_busy [2];
    int         m_pos  [2];
    logic [3:0] m_key  [2];
    logic [3:0] e_cols [2];
    logic       e_busy [2];
    logic       e_done [2];
    bit         m_c;

    always @(posedge clk or posedge rst) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_busy[k] = 1'b0;
                m_pos[k]  = 0;
                m_key[k]  = 4'b0000;
                e_cols[k] = 4'b0000;
                e_busy[k] = 1'b0;
                e_done[k] = 1'b0;
            end else begin
                m_c       = m_busy[k] && contact_at(k, m_pos[k]);
                e_cols[k] = (m_c && rows[m_key[k][3:2]]) ? (4'b0001 << m_key[k][1:0]) : 4'b0000;
                e_done[k] = 1'b0;
                if (!m_busy[k]) begin
                    if (press) begin
                        m_busy[k] = 1'b1;
                        m_pos[k]  = 0;
                        m_key[k]  = key_code;
                    end
                end else begin
                    m_pos[k] = m_pos[k] + 1;
                    if (m_pos[k] == 2 * bounce_of(k) + hold_of(k)) begin
                        m_busy[k] = 1'b0;
                        e_done[k] = 1'b1;
                    end
                end
                e_busy[k] = m_busy[k];
            end
        end
    end

    task automatic test_reset;
        #1 rst = 1'b1;
        #4;
        for (int k = 0; k < 2; k++) begin
            n_checks += 3;
            if (cols[k] !== 4'b0000) begin
                n_fail++;
                $display("[TB] FAIL reset_cols dut%0d: got %b required 0000", k, cols[k]);
            end
            if (busy[k] !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL reset_busy dut%0d: got %b required 0", k, busy[k]);
            end
            if (done[k] !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL reset_done dut%0d: got %b required 0", k, done[k]);
            end
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_clean_press;
        @(negedge clk);
        key_code = 4'b0110;
        rows     = 4'b0010;
        press    = 1'b1;
        @(negedge clk);
        press = 1'b0;
        n_checks += 2;
        if (busy[0] !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL clean_busy_edge0: got %b required 1", busy[0]);
        end
        if (cols[0] !== 4'b0000) begin
            n_fail++;
            $display("[TB] FAIL clean_cols_edge0: got %b required 0000", cols[0]);
        end
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            n_checks += 3;
            if (cols[0] !== ((i <= 8) ? 4'b0100 : 4'b0000)) begin
                n_fail++;
                $display("[TB] FAIL clean_cols edge%0d: got %b required %b", i, cols[0], (i <= 8) ? 4'b0100 : 4'b0000);
            end
            if (busy[0] !== (i <= 7)) begin
                n_fail++;
                $display("[TB] FAIL clean_busy edge%0d: got %b required %b", i, busy[0], (i <= 7));
            end
            if (done[0] !== (i == 8)) begin
                n_fail++;
                $display("[TB] FAIL clean_done edge%0d: got %b required %b", i, done[0], (i == 8));
            end
        end
        for (int n = 0; n < 300 && (busy[0] || busy[1]); n++) @(negedge clk);
        n_checks++;
        if (busy[0] || busy[1]) begin
            n_fail++;
            $display("[TB] FAIL clean_idle_timeout: busy=%b%b required 00", busy[0], busy[1]);
        end
    endtask

    task automatic test_row_gating;
        logic [3:0] prev;
        @(negedge clk);
        key_code = 4'b0110;
        rows     = 4'b0001;
        press    = 1'b1;
        @(negedge clk);
        press = 1'b0;
        rows  = 4'b0010;
        for (int i = 1; i <= 12; i++) begin
            prev = rows;
            @(negedge clk);
            n_checks++;
            if (cols[0] !== ((i <= 8 && prev == 4'b0010) ? 4'b0100 : 4'b0000)) begin
                n_fail++;
                $display("[TB] FAIL row_gating edge%0d rows=%b: got %b", i, prev, cols[0]);
            end
            rows = {rows[2:0], rows[3]};
        end
        for (int n = 0; n < 300 && (busy[0] || busy[1]); n++) @(negedge clk);
        // Randomised key and arbitrary (including non-one-hot) row drive.
        for (int rep = 0; rep < 3; rep++) begin
            key_code = 4'($urandom_range(0, 15));
            press    = 1'b1;
            for (int i = 0; i < 14; i++) begin
                rows = 4'($urandom_range(0, 15));
                @(negedge clk);
                press = 1'b0;
                for (int k = 0; k < 2; k++) begin
                    n_checks++;
                    if ({cols[k], busy[k], done[k]} !== {e_cols[k], e_busy[k], e_done[k]}) begin
                        n_fail++;
                        $display("[TB] FAIL rand_rows dut%0d: cols/busy/done=%b/%b/%b required %b/%b/%b",
                                 k, cols[k], busy[k], done[k], e_cols[k], e_busy[k], e_done[k]);
                    end
                end
            end
        end
        for (int n = 0; n < 300 && (busy[0] || busy[1]); n++) @(negedge clk);
        n_checks++;
        if (busy[0] || busy[1]) begin
            n_fail++;
            $display("[TB] FAIL rows_idle_timeout: busy=%b%b required 00", busy[0], busy[1]);
        end
    endtask

    task automatic test_bounce;
        logic [15:0] in_pat;
        logic [15:0] out_pat;
        logic        exp_bit;
        int          j;
        in_pat  = 16'b1111_0000_1111_0000;
        out_pat = 16'b0000_1111_0000_1111;
        @(negedge clk);
        key_code = 4'b0000;
        rows     = 4'b0001;
        press    = 1'b1;
        @(negedge clk);
        press = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            j = i - 1;
            if (j < 16) exp_bit = in_pat[15 - j];
            else if (j < 80) exp_bit = 1'b1;
            else if (j < 96) exp_bit = out_pat[15 - (j - 80)];
            else exp_bit = 1'b0;
            n_checks += 2;
            if (cols[1] !== {3'b000, exp_bit}) begin
                n_fail++;
                $display("[TB] FAIL bounce_cols edge%0d: got %b required %b", i, cols[1], {3'b000, exp_bit});
            end
            if (done[1] !== (i == 96)) begin
                n_fail++;
                $display("[TB] FAIL bounce_done edge%0d: got %b required %b", i, done[1], (i == 96));
            end
        end
        n_checks++;
        if (busy[0] || busy[1]) begin
            n_fail++;
            $display("[TB] FAIL bounce_idle: busy=%b%b required 00", busy[0], busy[1]);
        end
    endtask

    task automatic test_busy_press;
        int dones;
        dones = 0;
        @(negedge clk);
        key_code = 4'b0110;
        rows     = 4'b0010;
        press    = 1'b1;
        @(negedge clk);
        press = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            press    = (i == 3);
            key_code = (i == 3) ? 4'b1111 : 4'($urandom_range(0, 15));
            @(negedge clk);
            press = 1'b0;
            n_checks++;
            if (cols[0] !== ((i <= 8) ? 4'b0100 : 4'b0000)) begin
                n_fail++;
                $display("[TB] FAIL busy_press_cols edge%0d: got %b required %b", i, cols[0], (i <= 8) ? 4'b0100 : 4'b0000);
            end
            if (done[0]) dones++;
        end
        n_checks++;
        if (dones != 1) begin
            n_fail++;
            $display("[TB] FAIL busy_press_done_count: got %0d required 1", dones);
        end
        for (int n = 0; n < 300 && (busy[0] || busy[1]); n++) @(negedge clk);
        n_checks++;
        if (busy[0] || busy[1]) begin
            n_fail++;
            $display("[TB] FAIL busy_press_idle_timeout: busy=%b%b required 00", busy[0], busy[1]);
        end
    endtask

    task automatic test_async_reset;
        int  dones;
        bit  saw_cols;
        dones    = 0;
        saw_cols = 1'b0;
        @(negedge clk);
        key_code = 4'b0110;
        rows     = 4'b0010;
        press    = 1'b1;
        @(negedge clk);
        press = 1'b0;
        repeat (3) @(negedge clk);
        #3 rst = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if ({cols[k], busy[k], done[k]} !== 6'b0) begin
                n_fail++;
                $display("[TB] FAIL async_reset dut%0d: cols/busy/done=%b/%b/%b required 0000/0/0", k, cols[k], busy[k], done[k]);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            n_checks++;
            if ({busy[0], done[0], busy[1], done[1]} !== 4'b0000) begin
                n_fail++;
                $display("[TB] FAIL post_reset_quiet cycle%0d: busy/done=%b%b %b%b required 00 00", i, busy[0], done[0], busy[1], done[1]);
            end
        end
        press = 1'b1;
        @(negedge clk);
        press = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done[0]) dones++;
            if (cols[0] == 4'b0100) saw_cols = 1'b1;
        end
        n_checks += 2;
        if (dones != 1) begin
            n_fail++;
            $display("[TB] FAIL post_reset_press_done: got %0d required 1", dones);
        end
        if (!saw_cols) begin
            n_fail++;
            $display("[TB] FAIL post_reset_press_cols: got no 0100 required 0100");
        end
        for (int n = 0; n < 300 && (busy[0] || busy[1]); n++) @(negedge clk);
        n_checks++;
        if (busy[0] || busy[1]) begin
            n_fail++;
            $display("[TB] FAIL async_idle_timeout: busy=%b%b required 00", busy[0], busy[1]);
        end
    endtask

    task automatic test_back_to_back;
        int dones;
        bit prev_done;
        dones     = 0;
        prev_done = 1'b0;
        @(negedge clk);
        key_code = 4'b0110;
        rows     = 4'b0010;
        press    = 1'b1;
        for (int i = 1; i <= 45; i++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if ({cols[k], busy[k], done[k]} !== {e_cols[k], e_busy[k], e_done[k]}) begin
                    n_fail++;
                    $display("[TB] FAIL back_to_back dut%0d edge%0d: cols/busy/done=%b/%b/%b required %b/%b/%b",
                             k, i, cols[k], busy[k], done[k], e_cols[k], e_busy[k], e_done[k]);
                end
            end
            if (prev_done) begin
                n_checks++;
                if (busy[0] !== 1'b1) begin
                    n_fail++;
                    $display("[TB] FAIL back_to_back_gap edge%0d: busy got %b required 1", i, busy[0]);
                end
            end
            prev_done = done[0];
            if (done[0]) dones++;
        end
        n_checks++;
        if (dones != 5) begin
            n_fail++;
            $display("[TB] FAIL back_to_back_done_count: got %0d required 5", dones);
        end
        press = 1'b0;
        for (int n = 0; n < 300 && (busy[0] || busy[1]); n++) @(negedge clk);
        n_checks++;
        if (busy[0] || busy[1]) begin
            n_fail++;
            $display("[TB] FAIL b2b_idle_timeout: busy=%b%b required 00", busy[0], busy[1]);
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 400; i++) begin
            press    = ($urandom_range(0, 7) == 0);
            key_code = 4'($urandom_range(0, 15));
            rows     = ($urandom_range(0, 1) == 0) ? (4'b0001 << $urandom_range(0, 3)) : 4'($urandom_range(0, 15));
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if ({cols[k], busy[k], done[k]} !== {e_cols[k], e_busy[k], e_done[k]}) begin
                    n_fail++;
                    $display("[TB] FAIL random dut%0d cycle%0d: cols/busy/done=%b/%b/%b required %b/%b/%b",
                             k, i, cols[k], busy[k], done[k], e_cols[k], e_busy[k], e_done[k]);
                end
            end
        end
        press = 1'b0;
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_row_gating();
        test_bounce();
        test_busy_press();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
